// File: rtl/half_rate_pkg.sv
// Types shared by the half-rate feeder and the half-rate CDC stage it feeds.
package half_rate_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/feeder_fifo_mem.sv
// Storage array for the feeder FIFO: synchronous write port, asynchronous read port.
module feeder_fifo_mem
    import half_rate_pkg::*;
#(
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    word_t mem [DEPTH];

    // The array is deliberately left without reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/half_rate_feeder.sv
// Full-rate ready/valid FIFO that launches at most one word per half_clock period,
// holding each launched word stable for the whole period.
module half_rate_feeder
    import half_rate_pkg::*;
#(
    parameter  int CAPACITY = 32,
    localparam int PTR_W    = $clog2(CAPACITY),
    localparam int LVL_W    = $clog2(CAPACITY + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              half_clock,
    input  logic [WORD_W-1:0] t0_data,
    input  logic              t0_valid,
    output logic              t0_ready,
    output logic [WORD_W-1:0] i0_data,
    output logic              i0_valid,
    input  logic              i0_ready,
    output logic [LVL_W-1:0]  level
);

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(CAPACITY);

    logic              hc_q,       hc_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic              i0_valid_q, i0_valid_d;
    word_t             i0_data_q,  i0_data_d;

    logic  launch;
    logic  push;
    logic  pop;
    logic  stall;
    word_t rd_data;

    feeder_fifo_mem #(
        .DEPTH (CAPACITY)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (t0_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Ready depends only on registered occupancy, never on t0_valid.
    assign t0_ready = (level_q != FULL_LEVEL) && !reset;

    always_comb begin
        hc_d       = half_clock;
        launch     = half_clock && !hc_q;
        push       = t0_valid && t0_ready;
        stall      = i0_valid_q && !i0_ready;
        pop        = launch && !stall && (level_q != '0);

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        // Output register only moves on launch cycles; a stalled word is held.
        i0_valid_d = i0_valid_q;
        i0_data_d  = i0_data_q;
        if (launch && !stall) begin
            if (pop) begin
                i0_data_d  = rd_data;
                i0_valid_d = 1'b1;
            end else begin
                i0_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            i0_valid_q <= 1'b0;
            i0_data_q  <= '0;
        end else begin
            hc_q       <= hc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            i0_valid_q <= i0_valid_d;
            i0_data_q  <= i0_data_d;
        end
    end

    assign i0_data  = i0_data_q;
    assign i0_valid = i0_valid_q;
    assign level    = level_q;

endmodule

// File: tb/tb_half_rate_feeder.sv
// Directed bench for half_rate_feeder: half_clock period of 4 clk cycles, one task per scenario.
module tb_half_rate_feeder;
    import half_rate_pkg::*;

    localparam int CAP = 32;

    logic        clk;
    logic        reset;
    logic        half_clock;
    logic [31:0] t0_data;
    logic        t0_valid;
    logic        t0_ready;
    logic [31:0] i0_data;
    logic        i0_valid;
    logic        i0_ready;
    logic [5:0]  level;

    int total;
    int bad;
    int hc_ph;
    int exp_word;
    int exp_level;

    half_rate_feeder #(
        .CAPACITY (CAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .half_clock (half_clock),
        .t0_data    (t0_data),
        .t0_valid   (t0_valid),
        .t0_ready   (t0_ready),
        .i0_data    (i0_data),
        .i0_valid   (i0_valid),
        .i0_ready   (i0_ready),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // half_clock is high for phases 0,1 and low for 2,3; an edge taken with hc_ph==0 is a launch.
    task automatic tick();
        half_clock = (hc_ph < 2);
        @(posedge clk);
        #1;
        hc_ph = (hc_ph + 1) % 4;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 4 && hc_ph != ph; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; t0_valid = 1'b0; t0_data = '0; i0_ready = 1'b0;
        half_clock = 1'b0; hc_ph = 2;
        repeat (3) tick();
        total++; if (i0_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", i0_valid); end
        total++; if (i0_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0", i0_data); end
        total++; if (level !== 6'd0) begin bad++; $display("[TB] FAIL rst_level: got %0d want 0", level); end
        total++; if (t0_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_t0_ready: got %b want 0", t0_ready); end
        wait_phase(2);
        reset = 1'b0;
        #1;
        total++; if (t0_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_t0_ready: got %b want 1", t0_ready); end
    endtask

    task automatic test_single();
        wait_phase(3);
        i0_ready = 1'b1; t0_valid = 1'b1; t0_data = 32'hDEADBEEF;
        tick();
        t0_valid = 1'b0;
        total++; if (level !== 6'd1) begin bad++; $display("[TB] FAIL single_lvl_push: got %0d want 1", level); end
        total++; if (i0_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early: got %b want 0", i0_valid); end
        tick();
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_launch: got %b/%h want 1/deadbeef", i0_valid, i0_data); end
        total++; if (level !== 6'd0) begin bad++; $display("[TB] FAIL single_lvl_pop: got %0d want 0", level); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (i0_valid !== 1'b1 || i0_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_stable%0d: got %b/%h want 1/deadbeef", k, i0_valid, i0_data); end
        end
        tick();
        total++; if (i0_valid !== 1'b0 || i0_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_empty: got %b/%h want 0/deadbeef", i0_valid, i0_data); end
    endtask

    task automatic test_burst_full();
        int  idx;
        logic acc;
        idx = 0;
        i0_ready = 1'b0;
        wait_phase(1);
        for (int c = 0; c < 40; c++) begin
            t0_valid = 1'b1; t0_data = idx;
            acc = t0_ready;
            tick();
            if (acc) idx++;
        end
        t0_valid = 1'b0;
        total++; if (idx != 33) begin bad++; $display("[TB] FAIL burst_accepted: got %0d want 33", idx); end
        total++; if (t0_ready !== 1'b0) begin bad++; $display("[TB] FAIL burst_ready: got %b want 0", t0_ready); end
        total++; if (level !== 6'd32) begin bad++; $display("[TB] FAIL burst_level: got %0d want 32", level); end
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'd0) begin bad++; $display("[TB] FAIL burst_head: got %b/%h want 1/0", i0_valid, i0_data); end
    endtask

    task automatic test_drain();
        int          exp;
        logic        v;
        logic        was_launch;
        logic [31:0] d;
        exp = 0;
        wait_phase(0);
        total++; if (t0_ready !== 1'b0) begin bad++; $display("[TB] FAIL drain_pre_ready: got %b want 0", t0_ready); end
        i0_ready = 1'b1;
        for (int c = 0; c < 300 && exp < 33; c++) begin
            was_launch = (hc_ph == 0); v = i0_valid; d = i0_data;
            tick();
            if (was_launch && v) begin
                total++; if (d !== exp) begin bad++; $display("[TB] FAIL drain_word: got %h want %h", d, exp); end
                exp++;
                if (exp == 1) begin
                    total++; if (t0_ready !== 1'b1 || level !== 6'd31) begin bad++; $display("[TB] FAIL drain_first_pop: got %b/%0d want 1/31", t0_ready, level); end
                end
            end
        end
        total++; if (exp != 33) begin bad++; $display("[TB] FAIL drain_count: got %0d want 33", exp); end
        total++; if (i0_valid !== 1'b0 || level !== 6'd0) begin bad++; $display("[TB] FAIL drain_end: got %b/%0d want 0/0", i0_valid, level); end
    endtask

    task automatic test_wrap();
        int          nxt_push;
        int          nxt_out;
        logic        v;
        logic [31:0] d;
        i0_ready = 1'b0;
        wait_phase(1);
        for (int k = 0; k < 17; k++) begin
            t0_valid = 1'b1; t0_data = 32'h1000_0000 + k;
            tick();
        end
        t0_valid = 1'b0;
        total++; if (level !== 6'd16) begin bad++; $display("[TB] FAIL wrap_fill_level: got %0d want 16", level); end
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'h1000_0000) begin bad++; $display("[TB] FAIL wrap_fill_head: got %b/%h want 1/10000000", i0_valid, i0_data); end
        i0_ready = 1'b1;
        nxt_push = 17; nxt_out = 0;
        for (int n = 0; n < 200; n++) begin
            wait_phase(0);
            t0_valid = 1'b1; t0_data = 32'h1000_0000 + nxt_push;
            v = i0_valid; d = i0_data;
            tick();
            t0_valid = 1'b0;
            total++; if (v !== 1'b1 || d !== 32'h1000_0000 + nxt_out) begin bad++; $display("[TB] FAIL wrap_word: got %b/%h want 1/%h", v, d, 32'h1000_0000 + nxt_out); end
            total++; if (level !== 6'd16) begin bad++; $display("[TB] FAIL wrap_level: got %0d want 16", level); end
            nxt_out++; nxt_push++;
        end
        exp_word = 32'h1000_0000 + nxt_out;
        exp_level = 16;
    endtask

    task automatic test_backpressure();
        logic        v;
        logic [31:0] d;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4 && hc_ph != 0; i++) begin i0_ready = ~i0_ready; tick(); end
            i0_ready = 1'b1; v = i0_valid; d = i0_data;
            tick();
            exp_level--;
            total++; if (v !== 1'b1 || d !== exp_word) begin bad++; $display("[TB] FAIL bp_xfer: got %b/%h want 1/%h", v, d, exp_word); end
            exp_word++;
            total++; if (i0_data !== exp_word || level !== 6'(exp_level)) begin bad++; $display("[TB] FAIL bp_next: got %h/%0d want %h/%0d", i0_data, level, exp_word, exp_level); end
        end
        for (int i = 0; i < 4 && hc_ph != 0; i++) begin i0_ready = ~i0_ready; tick(); end
        i0_ready = 1'b0;
        tick();
        total++; if (i0_valid !== 1'b1 || i0_data !== exp_word || level !== 6'(exp_level)) begin bad++; $display("[TB] FAIL bp_stall: got %b/%h/%0d want 1/%h/%0d", i0_valid, i0_data, level, exp_word, exp_level); end
        for (int i = 0; i < 4 && hc_ph != 0; i++) begin i0_ready = ~i0_ready; tick(); end
        i0_ready = 1'b1; d = i0_data;
        tick();
        exp_level--;
        total++; if (d !== exp_word) begin bad++; $display("[TB] FAIL bp_held: got %h want %h", d, exp_word); end
        exp_word++;
        total++; if (i0_data !== exp_word || level !== 6'(exp_level)) begin bad++; $display("[TB] FAIL bp_resume: got %h/%0d want %h/%0d", i0_data, level, exp_word, exp_level); end
    endtask

    task automatic test_reset_mid();
        i0_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_phase(0);
            tick();
            exp_level--;
        end
        total++; if (level !== 6'd10 || i0_valid !== 1'b1 || exp_level != 10) begin bad++; $display("[TB] FAIL mid_setup: got %0d/%b want 10/1", level, i0_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (i0_valid !== 1'b0 || i0_data !== 32'h0) begin bad++; $display("[TB] FAIL mid_out: got %b/%h want 0/0", i0_valid, i0_data); end
        total++; if (level !== 6'd0) begin bad++; $display("[TB] FAIL mid_level: got %0d want 0", level); end
        total++; if (t0_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got %b want 0", t0_ready); end
        tick();
        tick();
        wait_phase(2);
        reset = 1'b0;
        t0_valid = 1'b1; t0_data = 32'hA000_0000;
        tick();
        t0_data = 32'hA000_0001;
        tick();
        t0_valid = 1'b0;
        total++; if (level !== 6'd2 || i0_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_push: got %0d/%b want 2/0", level, i0_valid); end
        tick();
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'hA000_0000 || level !== 6'd1) begin bad++; $display("[TB] FAIL post_first: got %b/%h/%0d want 1/a0000000/1", i0_valid, i0_data, level); end
        wait_phase(0);
        tick();
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'hA000_0001 || level !== 6'd0) begin bad++; $display("[TB] FAIL post_second: got %b/%h/%0d want 1/a0000001/0", i0_valid, i0_data, level); end
        wait_phase(0);
        tick();
        total++; if (i0_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_empty: got %b want 0", i0_valid); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_burst_full();
        test_drain();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_rate_feeder.md
# half_rate_feeder

Clock-domain-side buffer that sits directly upstream of the half-rate CDC stage. It accepts 32-bit words at full `clk` rate through a ready/valid port and stores them in a CAPACITY-deep FIFO. It launches at most one word per `half_clock` period, holding each word stable for that whole period so the half-rate stage can latch it on any `clk` edge inside the period. It absorbs bursts and back-pressures the producer only when the FIFO is full.

## Interface
- `CAPACITY`, 32, FIFO depth in words; power of two, ≥ 2.
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `half_clock`  in  1  half-rate clock, used as a data signal and sampled in `clk`; period ≥ 2 `clk` cycles.
- `t0_data`  in  32  input word.
- `t0_valid`  in  1  `t0_data` is valid.
- `t0_ready`  out  1  the block can accept a word this cycle.
- `i0_data`  out  32  launched word; changes only on launch cycles.
- `i0_valid`  out  1  `i0_data` is valid; changes only on launch cycles.
- `i0_ready`  in  1  downstream accepts; sampled only on launch cycles.
- `level`  out  $clog2(CAPACITY+1)  current FIFO occupancy, excluding the output register.

## Operation
- Edge detect: `hc_q <= half_clock`. A launch cycle is any cycle where `half_clock && !hc_q`.
- Push:
  - Occurs when `t0_valid && t0_ready`.
  - Writes `mem[wr_ptr]` and increments `wr_ptr` modulo CAPACITY.
- `t0_ready = (level != CAPACITY) && !reset`. The path is combinational from registered `level`; there is no path from `t0_valid`.
- Output register update happens only on launch cycles:
  - If `i0_valid && !i0_ready`: hold `i0_data` and `i0_valid` unchanged; no pop.
  - Otherwise, if `level != 0`: pop. Load `i0_data <= mem[rd_ptr]`, set `i0_valid <= 1`, increment `rd_ptr`.
  - Otherwise: `i0_valid <= 0` and `i0_data` holds its last value.
- A transfer to downstream is counted only on a launch cycle with `i0_valid && i0_ready`.
- `level` update rules:
  - Increments on push-only.
  - Decrements on pop-only.
  - Unchanged on simultaneous push and pop.
- Push at full is impossible because `t0_ready` is 0.
- Pop at empty is impossible by construction.
- Pointers use $clog2(CAPACITY) bits and wrap naturally, with no special case at the wrap point.
- Words are never dropped or duplicated, and order is strict FIFO.
- Reset values:
  - `i0_valid` = 0, `i0_data` = 0, `level` = 0.
  - Pointers = 0, `hc_q` = 0.
  - `t0_ready` = 0 while `reset` is high.
- Reset asserted mid-operation discards all buffered and launched words immediately (asynchronous).
- After release, the first launch cycle requires a fresh rising edge of `half_clock`.

## Timing
- Memory write is registered, so a word pushed in cycle n is readable from cycle n+1.
- Minimum latency: push at cycle n, FIFO empty, launch at cycle n+1 → `i0_valid`/`i0_data` visible at n+2.
- If no launch occurs at n+1, the word waits for the next launch cycle.
- Throughput:
  - Input: 1 word/`clk` until full.
  - Output: ≤ 1 word per `half_clock` period.
- `i0_*` is stable for the full `half_clock` period between consecutive launch cycles.
- `i0_ready` is ignored outside launch cycles, so downstream may toggle it freely mid-period.
- `t0_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees a slot, unless a simultaneous push occurred.
- No combinational path from `i0_ready` or `t0_valid` to any output.

## Structure
- `half_rate_pkg`: `WORD_W = 32` and `typedef logic [WORD_W-1:0] word_t`. The half-rate CDC stage shares this package.
- Sub-module `feeder_fifo_mem`:
  - Simple dual-port memory, synchronous write, asynchronous read, CAPACITY×32.
  - No reset on the storage array.
- Top level holds pointers, `level`, edge detector and output register.

## Test plan
- Single word: `half_clock` period 4 cycles, push `0xDEADBEEF` with FIFO empty → `i0_valid=1`, `i0_data=0xDEADBEEF` one cycle after the next launch cycle, stable 4 cycles, `level` returns to 0.
- Burst to full: CAPACITY=32, `i0_ready=0`, push 40 words `0..39` back-to-back → 33 accepted (32 in FIFO plus 1 in output register), `t0_ready=0` afterwards, `level=32`; word 0 held on `i0_data`.
- Drain ordering: from full, `i0_ready=1` → words 0..32 emitted one per `half_clock` period in order; `t0_ready` reasserts the cycle after the first pop.
- Wrap-around and simultaneous events: continuous push of an incrementing counter at 1/2 rate with `level` at 16 → 200 words pass; push and pop coincide on launch cycles, `level` stays steady, no loss or duplication.
- Backpressure mid-period: `i0_ready` toggles low/high between launch cycles but is high on launch cycles → no stall. `i0_ready=0` on a launch cycle → word held one more period.
- Reset mid-burst: assert `reset` with `level=10` and `i0_valid=1` → same-cycle `i0_valid=0`, `level=0`, `t0_ready=0`. After release, only newly pushed words appear.
